// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes on both sides.

module bcd_digit_adj (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);
  assign dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;
endmodule

module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_sh_q, bin_sh_d;
  logic [BW-1:0]     bcd_sh_q, bcd_sh_d;
  logic [BW-1:0]     bcd_out_q, bcd_out_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     bcd_shifted;

  // All digits corrected in parallel from the pre-correction value.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .dig_i (bcd_sh_q[4*g +: 4]),
      .dig_o (bcd_adj[4*g +: 4])
    );
  end

  assign bcd_shifted = {bcd_adj[BW-2:0], bin_sh_q[WIDTH-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sh_q  <= '0;
      bcd_sh_q  <= '0;
      bcd_out_q <= '0;
      cnt_q     <= '0;
    end else begin
      bin_sh_q  <= bin_sh_d;
      bcd_sh_q  <= bcd_sh_d;
      bcd_out_q <= bcd_out_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_sh_d  = bin_sh_q;
    bcd_sh_d  = bcd_sh_q;
    bcd_out_d = bcd_out_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_sh_d = bin_in;
          bcd_sh_d = '0;
          cnt_d    = CW'(WIDTH);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        bcd_sh_d = bcd_shifted;
        bin_sh_d = bin_sh_q << 1;
        cnt_d    = cnt_q - CW'(1);
        // Output register only updates on completion, so it holds the last
        // result through the next conversion.
        if (cnt_q == CW'(1)) begin
          bcd_out_d = bcd_shifted;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_out_q;

endmodule
